// File: rtl/td4_ctrl_pkg.sv
// Purpose: shared types and constants for the TD4 run controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package td4_ctrl_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;
    localparam int TD4_DIV_W  = 16;
    localparam int TD4_CNT_W  = 16;
    localparam int PROG_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    localparam logic [1:0] CMD_HALT = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

endpackage

// File: rtl/td4_run_controller_if.sv
// Purpose: host command / load stream, core control and program-memory write bundle.
// Latency: n/a (wires only).
// Backpressure: cmd_ready / ld_ready carried here, driven by the controller.
interface td4_run_controller_if import td4_ctrl_pkg::*; #(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W,
    parameter int DIV_W  = TD4_DIV_W,
    parameter int CNT_W  = TD4_CNT_W
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [DIV_W-1:0]  div;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] core_pc;
    logic              core_rst;
    logic              core_ce;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [1:0]        state;
    logic [CNT_W-1:0]  instr_cnt;

    // Host / environment side.
    modport master (
        output cmd_valid, cmd, ld_valid, ld_data, div, bp_en, bp_addr, core_pc,
        input  cmd_ready, ld_ready, core_rst, core_ce, prog_we, prog_addr,
               prog_wdata, state, instr_cnt
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd, ld_valid, ld_data, div, bp_en, bp_addr, core_pc,
        output cmd_ready, ld_ready, core_rst, core_ce, prog_we, prog_addr,
               prog_wdata, state, instr_cnt
    );
endinterface

// File: rtl/td4_prescaler.sv
// Purpose: free-running 0..div counter producing a single-cycle tick at count == div.
// Latency: tick is combinational from the count register; clr takes effect next edge.
// Backpressure: none; div is sampled live every cycle.
module td4_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_div);

    // Count up, restart after the terminal value; a count stranded above a
    // lowered div simply runs on to the natural wrap and then re-syncs.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == i_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/td4_run_controller.sv
// Purpose: TD4 sequencer - program load, core reset, run/step/halt/breakpoint via core_ce.
// Latency: accepted command changes state on the next edge; prog_we is combinational.
// Backpressure: cmd_ready low only while loading; ld_ready high only while loading.
module td4_run_controller import td4_ctrl_pkg::*; #(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W,
    parameter int DIV_W  = TD4_DIV_W,
    parameter int CNT_W  = TD4_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    td4_run_controller_if.slave  bus
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ld_addr;
    logic                r_step_pend;
    logic [CNT_W-1:0]    r_instr_cnt;

    logic                w_cmd_acc;
    logic                w_ld_acc;
    logic                w_ld_last;
    logic                w_tick;
    logic                w_bp_hit;
    logic                w_prs_clr;
    logic                w_cmd_ready;
    logic                w_ld_ready;
    logic                w_core_rst;
    logic                w_core_ce;
    logic                w_prog_we;
    logic [DATA_W-1:0]   w_prog_wdata;

    assign w_cmd_acc = bus.cmd_valid & w_cmd_ready;
    assign w_ld_acc  = bus.ld_valid & w_ld_ready;
    assign w_ld_last = w_ld_acc & (r_ld_addr == ADDR_W'(PROG_DEPTH - 1));
    assign w_bp_hit  = (r_state == ST_RUN) & w_tick & bus.bp_en &
                       (bus.core_pc == bus.bp_addr);

    // Prescaler is held at zero outside RUN so every RUN entry starts fresh.
    assign w_prs_clr = (r_state != ST_RUN);

    td4_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_prs_clr),
        .i_div  (bus.div),
        .o_tick (w_tick)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; in RUN an explicit command outranks a breakpoint,
    // though HALT/STEP and a breakpoint both land in PAUSE anyway.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    unique case (bus.cmd)
                        CMD_LOAD: w_state_nxt = ST_LOAD;
                        CMD_RUN:  w_state_nxt = ST_RUN;
                        CMD_STEP: w_state_nxt = ST_PAUSE;
                        default:  w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_ld_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_cmd_acc && bus.cmd == CMD_LOAD) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_cmd_acc && (bus.cmd == CMD_HALT || bus.cmd == CMD_STEP)) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_bp_hit) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_cmd_acc) begin
                    unique case (bus.cmd)
                        CMD_LOAD: w_state_nxt = ST_LOAD;
                        CMD_RUN:  w_state_nxt = ST_RUN;
                        CMD_HALT: w_state_nxt = ST_IDLE;
                        default:  w_state_nxt = ST_PAUSE;
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore-style outputs from state, plus the gated load write and core_ce.
    always_comb begin
        w_cmd_ready  = 1'b1;
        w_ld_ready   = 1'b0;
        w_core_rst   = 1'b1;
        w_core_ce    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_core_rst = 1'b1;
            end
            ST_LOAD: begin
                w_cmd_ready = 1'b0;
                w_ld_ready  = 1'b1;
                w_core_rst  = 1'b1;
            end
            ST_RUN: begin
                w_core_rst = 1'b0;
                w_core_ce  = w_tick & ~w_bp_hit;
            end
            ST_PAUSE: begin
                w_core_rst = 1'b0;
                w_core_ce  = r_step_pend;
            end
            default: begin
                w_core_rst = 1'b1;
            end
        endcase
        w_prog_we    = bus.ld_valid & w_ld_ready;
        w_prog_wdata = w_ld_ready ? bus.ld_data : '0;
    end

    // Load address: restarts at 0 on every LOAD command, wraps after the last byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ld_addr <= '0;
        end else if (w_cmd_acc && bus.cmd == CMD_LOAD) begin
            r_ld_addr <= '0;
        end else if (w_ld_acc) begin
            r_ld_addr <= r_ld_addr + 1'b1;
        end
    end

    // A STEP taken while paused becomes exactly one core_ce on the next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step_pend <= 1'b0;
        end else begin
            r_step_pend <= (r_state == ST_PAUSE) && w_cmd_acc && (bus.cmd == CMD_STEP);
        end
    end

    // Executed-instruction count; cleared whenever the core sits in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_core_rst) begin
            r_instr_cnt <= '0;
        end else if (w_core_ce) begin
            r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.ld_ready   = w_ld_ready;
    assign bus.core_rst   = w_core_rst;
    assign bus.core_ce    = w_core_ce;
    assign bus.prog_we    = w_prog_we;
    assign bus.prog_addr  = r_ld_addr;
    assign bus.prog_wdata = w_prog_wdata;
    assign bus.state      = r_state;
    assign bus.instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_td4_run_controller.sv
// Purpose: directed self-checking bench for td4_run_controller.
// Latency: inputs driven 1 time unit after posedge, outputs checked 1 unit later.
// Backpressure: host side honours cmd_ready / ld_ready as observed.
module tb_td4_run_controller;
    import td4_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   we_cnt;
    int   pulses;
    logic ce;
    logic [3:0] pc;

    always #5 clk = ~clk;

    td4_run_controller_if bus ();

    td4_run_controller dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h00;
        bus.div       = 16'd0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = 4'd0;
        bus.core_pc   = 4'd0;
        pc            = 4'd0;
        cyc();
        cyc();
        #1;
        chk("rst_state",     32'(bus.state), 0);
        chk("rst_core_rst",  32'(bus.core_rst), 1);
        chk("rst_core_ce",   32'(bus.core_ce), 0);
        chk("rst_prog_we",   32'(bus.prog_we), 0);
        chk("rst_prog_addr", 32'(bus.prog_addr), 0);
        chk("rst_prog_wd",   32'(bus.prog_wdata), 0);
        chk("rst_ld_ready",  32'(bus.ld_ready), 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_instr_cnt", 32'(bus.instr_cnt), 0);
        rst = 1'b0;

        // Full load, ld_valid gapped every other cycle.
        send_cmd(CMD_LOAD);
        we_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            bus.ld_valid = (i % 2 == 0);
            bus.ld_data  = 8'(i / 2);
            #1;
            chk("ld_we", 32'(bus.prog_we), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                chk("ld_addr",  32'(bus.prog_addr), 32'(i / 2));
                chk("ld_wdata", 32'(bus.prog_wdata), 32'(i / 2));
            end
            chk("ld_core_rst", 32'(bus.core_rst), 1);
            chk("ld_state",    32'(bus.state), 1);
            if (bus.prog_we) we_cnt++;
            cyc();
        end
        bus.ld_valid = 1'b0;
        #1;
        chk("ld_done_state", 32'(bus.state), 0);
        chk("ld_done_ready", 32'(bus.ld_ready), 0);
        chk("ld_done_crst",  32'(bus.core_rst), 1);
        chk("ld_we_count",   32'(we_cnt), 16);

        // Free run, div = 2: pulse on RUN cycles 3, 6, 9, 12.
        bus.div = 16'd2;
        send_cmd(CMD_RUN);
        for (int c = 1; c <= 12; c++) begin
            #1;
            chk("run2_ce",   32'(bus.core_ce), 32'(c % 3 == 0));
            chk("run2_crst", 32'(bus.core_rst), 0);
            cyc();
        end
        chk("run2_cnt", 32'(bus.instr_cnt), 4);
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_HALT;
        #1;
        chk("run2_halt_ce", 32'(bus.core_ce), 0);
        cyc();
        chk("pause_state",   32'(bus.state), 3);
        chk("pause_cnt_hold", 32'(bus.instr_cnt), 4);
        cyc();
        bus.cmd_valid = 1'b0;
        chk("halt_idle",     32'(bus.state), 0);
        chk("halt_crst",     32'(bus.core_rst), 1);
        chk("halt_cnt_edge", 32'(bus.instr_cnt), 4);
        cyc();
        chk("halt_cnt_clr",  32'(bus.instr_cnt), 0);

        // Breakpoint at PC 5 with div = 0 and a PC model stepping per pulse.
        bus.div     = 16'd0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 4'd5;
        pc          = 4'd0;
        bus.core_pc = pc;
        send_cmd(CMD_RUN);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            bus.core_pc = pc;
            #1;
            ce = bus.core_ce;
            cyc();
            if (ce) begin
                pulses++;
                pc = pc + 4'd1;
            end
        end
        chk("bp_pulses", 32'(pulses), 5);
        chk("bp_state",  32'(bus.state), 3);
        chk("bp_crst",   32'(bus.core_rst), 0);
        chk("bp_cnt",    32'(bus.instr_cnt), 5);

        // STEP at the breakpoint PC still produces one pulse.
        bus.core_pc   = pc;
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_STEP;
        #1;
        chk("step_pre_ce", 32'(bus.core_ce), 0);
        cyc();
        bus.cmd_valid = 1'b0;
        #1;
        chk("step_ce", 32'(bus.core_ce), 1);
        cyc();
        pc          = pc + 4'd1;
        bus.core_pc = pc;
        #1;
        chk("step_post_ce", 32'(bus.core_ce), 0);
        chk("step_state",   32'(bus.state), 3);
        chk("step_cnt",     32'(bus.instr_cnt), 6);

        // Two STEPs back to back give two consecutive pulses.
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_STEP;
        cyc();
        #1;
        chk("step2_ce_a", 32'(bus.core_ce), 1);
        cyc();
        bus.cmd_valid = 1'b0;
        #1;
        chk("step2_ce_b", 32'(bus.core_ce), 1);
        cyc();
        #1;
        chk("step2_ce_c", 32'(bus.core_ce), 0);
        chk("step2_cnt",  32'(bus.instr_cnt), 8);
        send_cmd(CMD_HALT);
        #1;
        chk("halt2_state", 32'(bus.state), 0);
        chk("halt2_crst",  32'(bus.core_rst), 1);
        cyc();
        chk("halt2_cnt",   32'(bus.instr_cnt), 0);
        bus.bp_en = 1'b0;

        // Mid-load reset after 7 bytes, with a RUN command held throughout.
        send_cmd(CMD_LOAD);
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_RUN;
        for (int i = 0; i < 7; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(8'hA0 + i);
            #1;
            chk("ml_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("ml_addr",      32'(bus.prog_addr), 32'(i));
            cyc();
        end
        chk("ml_state", 32'(bus.state), 1);
        chk("ml_addr7", 32'(bus.prog_addr), 7);
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        chk("mr_state",     32'(bus.state), 0);
        chk("mr_crst",      32'(bus.core_rst), 1);
        chk("mr_ce",        32'(bus.core_ce), 0);
        chk("mr_ld_ready",  32'(bus.ld_ready), 0);
        chk("mr_prog_we",   32'(bus.prog_we), 0);
        chk("mr_prog_addr", 32'(bus.prog_addr), 0);
        chk("mr_prog_wd",   32'(bus.prog_wdata), 0);
        chk("mr_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mr_cnt",       32'(bus.instr_cnt), 0);
        bus.ld_valid = 1'b0;

        // Fresh load restarts at address 0 and completes.
        send_cmd(CMD_LOAD);
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(8'h30 + i);
            #1;
            chk("rl_we",    32'(bus.prog_we), 1);
            chk("rl_addr",  32'(bus.prog_addr), 32'(i));
            chk("rl_wdata", 32'(bus.prog_wdata), 32'(8'h30 + i));
            cyc();
        end
        bus.ld_valid = 1'b0;
        #1;
        chk("rl_state", 32'(bus.state), 0);

        // RUN, then HALT and RUN accepted on consecutive cycles, div = 3.
        bus.div = 16'd3;
        send_cmd(CMD_RUN);
        #1;
        chk("hr_run", 32'(bus.state), 2);
        cyc();
        send_cmd(CMD_HALT);
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_RUN;
        #1;
        chk("hr_pause",    32'(bus.state), 3);
        chk("hr_pause_ce", 32'(bus.core_ce), 0);
        cyc();
        bus.cmd_valid = 1'b0;
        chk("hr_rerun", 32'(bus.state), 2);
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("hr_ce", 32'(bus.core_ce), 32'(c % 4 == 0));
            cyc();
        end
        chk("hr_cnt", 32'(bus.instr_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
